// File: rtl/median_pkg.sv
// -----------------------------------------------------------------------------
// median_pkg
// Shared types and defaults for the median filter column feeder.
//   DEF_DATA_WIDTH / DEF_IMG_WIDTH / DEF_IMG_HEIGHT : default geometry
//   pixel_t       : one pixel at the default width
//   col_triple_t  : vertical column triple {s1 = row r-2, s2 = row r-1, s3 = row r}
//   DEF_COL_W / DEF_ROW_W : counter widths for the default geometry
// -----------------------------------------------------------------------------
package median_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_IMG_WIDTH  = 640;
  localparam int DEF_IMG_HEIGHT = 480;

  localparam int DEF_COL_W = $clog2(DEF_IMG_WIDTH);
  localparam int DEF_ROW_W = $clog2(DEF_IMG_HEIGHT);

  typedef logic [DEF_DATA_WIDTH-1:0] pixel_t;

  typedef struct packed {
    pixel_t s1;
    pixel_t s2;
    pixel_t s3;
  } col_triple_t;

endpackage

// File: rtl/median_line_buffer.sv
// -----------------------------------------------------------------------------
// median_line_buffer
// DEPTH-entry circular delay line. When en is high the entry at the current
// pointer is presented on rd_data (combinational), overwritten with wr_data at
// the clock edge, and the pointer advances, wrapping at DEPTH-1 by compare.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (pointer only;
//                   storage contents are don't-care after reset)
//   en            : advance one entry this cycle
//   wr_data       : value stored at the current pointer
//   rd_data       : value written DEPTH enabled cycles ago
// -----------------------------------------------------------------------------
module median_line_buffer #(
  parameter int DEPTH      = 640,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      ptr;

  assign rd_data = mem[ptr];

  always_ff @(posedge clk) begin
    if (en) begin
      mem[ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (en) begin
      if (ptr == PTR_LAST) begin
        ptr <= '0;
      end else begin
        ptr <= ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/median_column_feeder.sv
// -----------------------------------------------------------------------------
// median_column_feeder
// Producer side of the 3-input column sorter. Takes a raster pixel stream,
// keeps the two previous lines in delay lines and emits one vertical triple
// (S1 = row r-2, S2 = row r-1, S3 = row r, same column) per accepted pixel.
//
// Build option: define MEDIAN_FEEDER_REPLICATE_BORDER_EN to replicate the top
// border so rows 0 and 1 also produce triples (row 0: S1=S2=S3=pixel,
// row 1: S1=S2=row 0 pixel). Without it, rows 0 and 1 only fill the buffers.
//
// Handshake: a transfer happens on a side when its valid and ready are both
// high at the rising edge. i_ready = ~o_valid | o_ready, so the single output
// register is refilled in the same edge it is drained and the stream runs at
// full rate while o_ready is high; while o_valid & ~o_ready everything holds.
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   i_valid/i_data/i_ready : pixel input, raster order
//   o_valid/o_ready        : triple output handshake
//   S1, S2, S3    : column triple (rows r-2, r-1, r)
//   o_line_end    : qualifies the last triple of an output line
//   o_frame_done  : one-cycle pulse after the last triple of a frame transfers
// -----------------------------------------------------------------------------
module median_column_feeder
  import median_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  i_ready,
  input  logic                  o_ready,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] S1,
  output logic [DATA_WIDTH-1:0] S2,
  output logic [DATA_WIDTH-1:0] S3,
  output logic                  o_line_end,
  output logic                  o_frame_done
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [ROW_W-1:0] ROW_FULL  = ROW_W'(2);

  logic [COL_W-1:0]      col;
  logic [ROW_W-1:0]      row;
  logic                  in_fire;
  logic                  out_fire;
  logic                  col_last;
  logic                  row_last;
  logic                  emit;
  logic                  last_q;   // current output triple closes the frame
  logic [DATA_WIDTH-1:0] buf1_rd;  // row r-1 at col
  logic [DATA_WIDTH-1:0] buf0_rd;  // row r-2 at col
  logic [DATA_WIDTH-1:0] nxt_s1;
  logic [DATA_WIDTH-1:0] nxt_s2;
  logic [DATA_WIDTH-1:0] nxt_s3;

  assign i_ready  = ~o_valid | o_ready;
  assign in_fire  = i_valid & i_ready;
  assign out_fire = o_valid & o_ready;
  assign col_last = (col == COL_LAST);
  assign row_last = (row == ROW_LAST);

  // buf1 holds the previous line; the value it drops is the line before that,
  // which cascades into buf0. Both advance only on an input transfer, so their
  // pointers stay aligned with col.
  median_line_buffer #(
    .DEPTH      (IMG_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf1 (
    .clk     (clk),
    .rst     (rst),
    .en      (in_fire),
    .wr_data (i_data),
    .rd_data (buf1_rd)
  );

  median_line_buffer #(
    .DEPTH      (IMG_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf0 (
    .clk     (clk),
    .rst     (rst),
    .en      (in_fire),
    .wr_data (buf1_rd),
    .rd_data (buf0_rd)
  );

  always_comb begin
    nxt_s1 = buf0_rd;
    nxt_s2 = buf1_rd;
    nxt_s3 = i_data;
`ifdef MEDIAN_FEEDER_REPLICATE_BORDER_EN
    emit = 1'b1;
    if (row == '0) begin
      // Buffers hold nothing of this frame yet: replicate the pixel itself.
      nxt_s1 = i_data;
      nxt_s2 = i_data;
    end else if (row == ROW_W'(1)) begin
      // Only row 0 is available above: use it for both upper taps.
      nxt_s1 = buf1_rd;
    end
`else
    emit = (row >= ROW_FULL);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid      <= 1'b0;
      S1           <= '0;
      S2           <= '0;
      S3           <= '0;
      o_line_end   <= 1'b0;
      o_frame_done <= 1'b0;
      last_q       <= 1'b0;
      col          <= '0;
      row          <= '0;
    end else begin
      o_frame_done <= out_fire & last_q;

      if (in_fire) begin
        // Either the register was empty or it drains this same edge.
        o_valid    <= emit;
        o_line_end <= emit & col_last;
        last_q     <= emit & col_last & row_last;
        if (emit) begin
          S1 <= nxt_s1;
          S2 <= nxt_s2;
          S3 <= nxt_s3;
        end

        if (col_last) begin
          col <= '0;
          if (row_last) begin
            row <= '0;
          end else begin
            row <= row + 1'b1;
          end
        end else begin
          col <= col + 1'b1;
        end
      end else if (out_fire) begin
        o_valid    <= 1'b0;
        o_line_end <= 1'b0;
        last_q     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_median_column_feeder.sv
module tb_median_column_feeder;
  import median_pkg::*;

  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int N  = W * H;
`ifdef MEDIAN_FEEDER_REPLICATE_BORDER_EN
  localparam int TPF = N;
`else
  localparam int TPF = W * (H - 2);
`endif
  localparam int EW = 3 * DW + 2;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          i_valid;
  pixel_t        i_data;
  logic          i_ready;
  logic          o_ready;
  logic          o_valid;
  logic [DW-1:0] S1, S2, S3;
  logic          o_line_end;
  logic          o_frame_done;

  always #5 clk = ~clk;

  median_column_feeder #(
    .DATA_WIDTH (DW),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_valid      (i_valid),
    .i_data       (i_data),
    .i_ready      (i_ready),
    .o_ready      (o_ready),
    .o_valid      (o_valid),
    .S1           (S1),
    .S2           (S2),
    .S3           (S3),
    .o_line_end   (o_line_end),
    .o_frame_done (o_frame_done)
  );

  // ---------------- scoreboard state ----------------
  // entry = {s1, s2, s3, line_end, frame_last}
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] frame_exp[$];
  int            total = 0;
  int            bad   = 0;
  int            done_cnt;
  int            xfer_cnt;
  logic          check_en = 1'b0;
  logic          pending_done = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected triples of one 0..N-1 frame, built from row/col of each pixel.
  task automatic build_model();
    logic [DW-1:0] a, b, d;
    logic          le, lst;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        int p;
        p   = r * W + c;
        d   = DW'(p);
        le  = (c == W - 1);
        lst = le && (r == H - 1);
`ifdef MEDIAN_FEEDER_REPLICATE_BORDER_EN
        if (r == 0) begin
          a = d; b = d;
        end else if (r == 1) begin
          a = DW'(p - W); b = DW'(p - W);
        end else begin
          a = DW'(p - 2 * W); b = DW'(p - W);
        end
        frame_exp.push_back({a, b, d, le, lst});
`else
        if (r >= 2) begin
          a = DW'(p - 2 * W); b = DW'(p - W);
          frame_exp.push_back({a, b, d, le, lst});
        end
`endif
      end
    end
  endtask

  // Monitor: sample away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      logic [EW-1:0] e;
      chk("frame_done", {31'd0, o_frame_done}, {31'd0, pending_done});
      if (o_frame_done) done_cnt++;
      pending_done = 1'b0;
      if (o_valid && o_ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          chk("extra_triple", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("triple", {7'd0, S1, S2, S3, o_line_end}, {7'd0, e[EW-1:1]});
          pending_done = e[0];
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_pixel(input int p);
    int n;
    n = 0;
    i_valid = 1'b1;
    i_data  = pixel_t'(p);
    @(negedge clk);
    while (!i_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!i_ready) chk("input_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic send_pixels(input int count);
    for (int i = 0; i < count; i++) push_pixel(i % N);
  endtask

  task automatic start_scn(input int frames);
    exp_q.delete();
    for (int f = 0; f < frames; f++)
      foreach (frame_exp[k]) exp_q.push_back(frame_exp[k]);
    done_cnt     = 0;
    xfer_cnt     = 0;
    pending_done = 1'b0;
    check_en     = 1'b1;
  endtask

  task automatic drain_and_check(input string tag, input int frames);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_queue_empty"}, exp_q.size(), 32'd0);
    chk({tag, "_triple_count"}, xfer_cnt, frames * TPF);
    chk({tag, "_done_pulses"}, done_cnt, frames);
    check_en = 1'b0;
  endtask

  // Hold o_ready low for three cycles once the second triple is on the output.
  task automatic stall_second();
    int n;
    n = 0;
    @(posedge clk);
    #1;
    while (!(o_valid && xfer_cnt == 1) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("stall_found", {31'd0, o_valid}, 32'd1);
    o_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_hold", {8'd0, S1, S2, S3}, {8'd0, frame_exp[1][EW-1:2]});
      chk("stall_valid", {31'd0, o_valid}, 32'd1);
      chk("stall_iready", {31'd0, i_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    o_ready = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst     = 1'b1;
    i_valid = 1'b0;
    i_data  = '0;
    o_ready = 1'b1;
    build_model();

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_o_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_s", {8'd0, S1, S2, S3}, 32'd0);
    chk("rst_line_end", {31'd0, o_line_end}, 32'd0);
    chk("rst_frame_done", {31'd0, o_frame_done}, 32'd0);
    chk("rst_i_ready", {31'd0, i_ready}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // basic stream
    start_scn(1);
    send_pixels(N);
    drain_and_check("basic", 1);

    // backpressure on the second triple
    start_scn(1);
    fork
      send_pixels(N);
      stall_second();
    join
    drain_and_check("stall", 1);

    // two frames back to back
    start_scn(2);
    send_pixels(2 * N);
    drain_and_check("b2b", 2);

    // reset mid-frame, then a clean frame
    check_en = 1'b0;
    send_pixels(10);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_o_valid", {31'd0, o_valid}, 32'd0);
    chk("midrst_frame_done", {31'd0, o_frame_done}, 32'd0);
    @(posedge clk);
    #1;
    start_scn(1);
    send_pixels(N);
    drain_and_check("after_rst", 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
